servo_pwm_out: RTL and testbench

//   Servo pulse transmitter: the output end of the servo threshold path. Takes the

---
 rtl/servo_pwm_out.sv | 101 ++++++++++
 tb/tb_servo_pwm_out.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_out.sv
// Servo PWM transmitter: clamps the commanded width, slews the applied width once per
// period and only switches width/enable on period boundaries.
module servo_pwm_out #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = 800,
    parameter int MAX_US      = 2150,
    parameter int INIT_US     = 1500,
    parameter int MAX_STEP_US = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [14:0] thres_in,
    input  logic        thres_valid,
    output logic        pwm_out,
    output logic        frame_start,
    output logic [14:0] active_thres
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000000;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(TICK_DIV - 1);
    localparam logic [14:0]     PERIOD_LAST = 15'(PERIOD_US - 1);
    localparam logic [14:0]     MIN_V       = 15'(MIN_US);
    localparam logic [14:0]     MAX_V       = 15'(MAX_US);
    localparam logic [14:0]     INIT_V      = 15'(INIT_US);
    localparam logic [14:0]     STEP_V      = 15'(MAX_STEP_US);

    function automatic logic [14:0] clamp_width(input logic [14:0] w);
        if (w < MIN_V)      return MIN_V;
        else if (w > MAX_V) return MAX_V;
        else                return w;
    endfunction

    // Both sides stay in range: active <= MAX_US and target+STEP fits in 15 bits.
    function automatic logic [14:0] slew_width(input logic [14:0] tgt, input logic [14:0] act);
        if (tgt > act + STEP_V)      return act + STEP_V;
        else if (tgt + STEP_V < act) return act - STEP_V;
        else                         return tgt;
    endfunction

    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [14:0]     us_cnt_q, us_cnt_d;
    logic [14:0]     target_q, target_d;
    logic [14:0]     active_q, active_d;
    logic            en_q, en_d;
    logic            pwm_q, pwm_d;
    logic            frame_q, frame_d;
    logic            tick;
    logic            boundary;

    always_comb begin
        tick        = (prescaler_q == PS_LAST);
        boundary    = tick && (us_cnt_q == PERIOD_LAST);
        prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);

        us_cnt_d = us_cnt_q;
        if (boundary)  us_cnt_d = '0;
        else if (tick) us_cnt_d = us_cnt_q + 15'd1;

        target_d = thres_valid ? clamp_width(thres_in) : target_q;

        active_d = active_q;
        en_d     = en_q;
        if (boundary) begin
            active_d = slew_width(target_q, active_q);
            en_d     = enable;
        end

        frame_d = boundary;
        // Computed from next-state values so the pulse rises together with frame_start.
        pwm_d   = en_d && (us_cnt_d < active_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            us_cnt_q    <= '0;
            target_q    <= INIT_V;
            active_q    <= INIT_V;
            en_q        <= 1'b0;
            pwm_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            us_cnt_q    <= us_cnt_d;
            target_q    <= target_d;
            active_q    <= active_d;
            en_q        <= en_d;
            pwm_q       <= pwm_d;
            frame_q     <= frame_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign frame_start  = frame_q;
    assign active_thres = active_q;

endmodule

// File: tb/tb_servo_pwm_out.sv
// Testbench for servo_pwm_out: table of width commands, hand-written boundary/enable/reset
// sequences, and a randomized phase checked cycle-by-cycle against a period-level model.
module tb_servo_pwm_out;

    localparam int CLK_HZ = 2000000;
    localparam int T      = CLK_HZ / 1000000;
    localparam int P      = 1300;
    localparam int MINU   = 800;
    localparam int MAXU   = 1200;
    localparam int INITU  = 1000;
    localparam int STEP   = 50;
    localparam int PT     = P * T;
    localparam int WIN    = MAXU * T + 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] thres_in = '0;
    logic        thres_valid = 1'b0;
    logic        pwm_out;
    logic        frame_start;
    logic [14:0] active_thres;

    int checks = 0;
    int errors = 0;

    servo_pwm_out #(
        .CLK_FREQ_HZ(CLK_HZ), .PERIOD_US(P), .MIN_US(MINU), .MAX_US(MAXU),
        .INIT_US(INITU), .MAX_STEP_US(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .thres_in(thres_in),
        .thres_valid(thres_valid), .pwm_out(pwm_out), .frame_start(frame_start),
        .active_thres(active_thres)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute clock count since reset; period k starts at count k*PT.
    int m_c, m_act, m_tgt, m_en;
    always @(posedge clk or negedge rst_n) begin
        int diff;
        if (!rst_n) begin
            m_c = 0; m_act = INITU; m_tgt = INITU; m_en = 0;
        end else begin
            if ((m_c + 1) % PT == 0) begin
                diff = m_tgt - m_act;
                if (diff > STEP)       m_act = m_act + STEP;
                else if (diff < -STEP) m_act = m_act - STEP;
                else                   m_act = m_tgt;
                m_en = enable ? 1 : 0;
            end
            if (thres_valid)
                m_tgt = (int'(thres_in) < MINU) ? MINU : (int'(thres_in) > MAXU) ? MAXU : int'(thres_in);
            m_c++;
        end
    end

    always @(negedge clk) begin
        int pos;
        pos = m_c % PT;
        check("model_pwm", int'(pwm_out), (m_en != 0 && pos < m_act * T) ? 1 : 0);
        check("model_frame", int'(frame_start), (m_c > 0 && pos == 0) ? 1 : 0);
        check("model_active", int'(active_thres), m_act);
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * PT);
        check("frame_wait", int'(frame_start), 1);
    endtask

    task automatic count_high(output int hi, input int drop_at, input int raise_at);
        hi = 0;
        for (int i = 0; i < WIN; i++) begin
            if (i == drop_at)  enable = 1'b0;
            if (i == raise_at) enable = 1'b1;
            if (pwm_out) hi++;
            @(negedge clk);
        end
    endtask

    task automatic send(input int v);
        thres_in = 15'(v);
        thres_valid = 1'b1;
        @(negedge clk);
        thres_valid = 1'b0;
    endtask

    typedef struct {
        int thres;
        bit en;
        int exp_act;
        int exp_high;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int hi;
        tbl[0]  = '{1020,  1'b1, 1020, 2040};
        tbl[1]  = '{3000,  1'b1, 1070, 2140};
        tbl[2]  = '{1100,  1'b1, 1100, 2200};
        tbl[3]  = '{100,   1'b1, 1050, 2100};
        tbl[4]  = '{0,     1'b1, 1000, 2000};
        tbl[5]  = '{1000,  1'b0, 1000, 0};
        tbl[6]  = '{32767, 1'b1, 1050, 2100};
        tbl[7]  = '{1200,  1'b1, 1100, 2200};
        tbl[8]  = '{1200,  1'b1, 1150, 2300};
        tbl[9]  = '{1200,  1'b1, 1200, 2400};
        tbl[10] = '{1300,  1'b1, 1200, 2400};
        tbl[11] = '{800,   1'b1, 1150, 2300};

        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_frame", int'(frame_start), 0);
        check("rst_active", int'(active_thres), INITU);
        enable = 1'b1;
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);

        foreach (tbl[i]) begin
            enable = tbl[i].en;
            send(tbl[i].thres);
            wait_frame();
            check($sformatf("tbl%0d_active", i), int'(active_thres), tbl[i].exp_act);
            count_high(hi, -1, -1);
            check($sformatf("tbl%0d_high", i), hi, tbl[i].exp_high);
        end

        // Valid on the boundary cycle only reaches active one period later.
        send(1150);
        wait_frame();
        check("bnd_pre", int'(active_thres), 1150);
        repeat (PT - 1) @(negedge clk);
        send(1160);
        check("bnd_frame", int'(frame_start), 1);
        check("bnd_same", int'(active_thres), 1150);
        wait_frame();
        check("bnd_next", int'(active_thres), 1160);

        // Enable dropped at us_cnt=500: pulse completes, next period stays low.
        count_high(hi, 500 * T, -1);
        check("en_drop_high", hi, 1160 * T);
        wait_frame();
        count_high(hi, -1, 100);
        check("en_off_high", hi, 0);

        // Reset at us_cnt=700 mid-pulse.
        wait_frame();
        repeat (700 * T) @(negedge clk);
        check("mid_pulse", int'(pwm_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pwm", int'(pwm_out), 0);
        check("async_active", int'(active_thres), INITU);
        check("async_frame", int'(frame_start), 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomized commands and enable toggles.
        for (int c = 0; c < 5 * PT; c++) begin
            @(negedge clk);
            thres_valid = ($urandom_range(0, 99) < 3);
            thres_in = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(1300, 32767))
                                                   : 15'($urandom_range(0, 1400));
            if ($urandom_range(0, 1999) == 0) enable = ~enable;
        end
        thres_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
